// File: rtl/func_arg_sequencer.sv
// func_arg_sequencer: gathers NARGS streamed arguments, strobes a call,
// samples the evaluator result after WAIT_CYCLES and hands it downstream.
module func_arg_sequencer #(
  parameter int WIDTH       = 1,
  parameter int NARGS       = 3,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 8,
  localparam int RES_W      = WIDTH + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arg_valid,
  input  logic [WIDTH-1:0]       arg_data,
  output logic                   arg_ready,
  output logic                   call_start,
  output logic [NARGS*WIDTH-1:0] call_args,
  input  logic [RES_W-1:0]       call_result,
  output logic                   res_valid,
  output logic [RES_W-1:0]       res_data,
  input  logic                   res_ready,
  output logic [CNT_W-1:0]       call_count
);

  localparam int IW = (NARGS > 1) ? $clog2(NARGS) : 1;
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    COLLECT,
    CALL,
    WAIT,
    OUTPUT
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wcnt;

  // Handshake strobes decode straight from the state register.
  assign arg_ready  = (state == COLLECT);
  assign call_start = (state == CALL);
  assign res_valid  = (state == OUTPUT);

  // Sequencer FSM together with argument slots, result and call counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      idx        <= '0;
      wcnt       <= '0;
      call_args  <= '0;
      res_data   <= '0;
      call_count <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (arg_valid) begin
            for (int i = 0; i < NARGS; i++) begin
              if (idx == IW'(i)) begin
                call_args[i*WIDTH +: WIDTH] <= arg_data;
              end
            end
            if (idx == IW'(NARGS - 1)) begin
              idx   <= '0;
              state <= CALL;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        CALL: begin
          if (WAIT_CYCLES == 0) begin
            res_data <= call_result;
            state    <= OUTPUT;
          end else begin
            wcnt  <= WW'(WAIT_CYCLES - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            res_data <= call_result;
            state    <= OUTPUT;
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            call_count <= call_count + CNT_W'(1);
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_func_arg_sequencer.sv
// tb_func_arg_sequencer: three instances (wait 1/0/4) on shared stimulus,
// checked every cycle against a transaction-age model plus literals.
module tb_func_arg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       av  = 1'b1;
  logic       ad  = 1'b1;
  logic       rr  = 1'b1;
  logic [2:0] cr  = 3'd7;
  logic       chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       ar0, cs0, rv0;
  logic [2:0] ca0, rd0;
  logic [7:0] cc0;
  logic       ar1, cs1, rv1;
  logic [2:0] ca1, rd1;
  logic [7:0] cc1;
  logic       ar2, cs2, rv2;
  logic [2:0] ca2, rd2;
  logic [1:0] cc2;

  func_arg_sequencer #(.WIDTH(1), .NARGS(3), .WAIT_CYCLES(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .arg_valid(av), .arg_data(ad), .arg_ready(ar0),
    .call_start(cs0), .call_args(ca0), .call_result(cr), .res_valid(rv0),
    .res_data(rd0), .res_ready(rr), .call_count(cc0)
  );

  func_arg_sequencer #(.WIDTH(1), .NARGS(3), .WAIT_CYCLES(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .arg_valid(av), .arg_data(ad), .arg_ready(ar1),
    .call_start(cs1), .call_args(ca1), .call_result(cr), .res_valid(rv1),
    .res_data(rd1), .res_ready(rr), .call_count(cc1)
  );

  func_arg_sequencer #(.WIDTH(1), .NARGS(3), .WAIT_CYCLES(4), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .arg_valid(av), .arg_data(ad), .arg_ready(ar2),
    .call_start(cs2), .call_args(ca2), .call_result(cr), .res_valid(rv2),
    .res_data(rd2), .res_ready(rr), .call_count(cc2)
  );

  // Model: a call is either collecting, or busy with an age in cycles
  // since the last argument was taken.
  int         wv[3] = '{1, 0, 4};
  int         cw[3] = '{8, 8, 2};
  bit         busy[3];
  int         age[3];
  int         nacc[3];
  logic [2:0] slots[3];
  logic [2:0] rdat[3];
  int         cnt[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        busy[i]  = 1'b0;
        age[i]   = 0;
        nacc[i]  = 0;
        slots[i] = 3'd0;
        rdat[i]  = 3'd0;
        cnt[i]   = 0;
      end else if (!busy[i]) begin
        if (av) begin
          slots[i][nacc[i]] = ad;
          if (nacc[i] == 2) begin
            nacc[i] = 0;
            busy[i] = 1'b1;
            age[i]  = 0;
          end else begin
            nacc[i] = nacc[i] + 1;
          end
        end
      end else if (age[i] >= 1 + wv[i]) begin
        if (rr) begin
          busy[i] = 1'b0;
          cnt[i]  = (cnt[i] + 1) % (1 << cw[i]);
        end
      end else begin
        age[i] = age[i] + 1;
        if (age[i] == 1 + wv[i]) rdat[i] = cr;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic a, input logic c,
                          input logic v, input logic [2:0] args,
                          input logic [2:0] rd, input logic [7:0] cc);
    cmp($sformatf("u%0d.arg_ready", i), 32'(a), 32'(!busy[i]));
    cmp($sformatf("u%0d.call_start", i), 32'(c),
        32'(busy[i] && age[i] == 0));
    cmp($sformatf("u%0d.res_valid", i), 32'(v),
        32'(busy[i] && age[i] >= 1 + wv[i]));
    cmp($sformatf("u%0d.call_args", i), 32'(args), 32'(slots[i]));
    cmp($sformatf("u%0d.res_data", i), 32'(rd), 32'(rdat[i]));
    cmp($sformatf("u%0d.call_count", i), 32'(cc), 32'(cnt[i]));
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst(0, ar0, cs0, rv0, ca0, rd0, cc0);
      chk_inst(1, ar1, cs1, rv1, ca1, rd1, cc1);
      chk_inst(2, ar2, cs2, rv2, ca2, rd2, {6'd0, cc2});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int         first[3];
  int         pulses;
  logic [1:0] prev;
  logic [1:0] q[$];
  int         wexp[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset with every input high.
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    cmp("rst.arg_ready", 32'(ar0), 32'd1);
    cmp("rst.call_start", 32'(cs0), 32'd0);
    cmp("rst.call_args", 32'(ca0), 32'd0);
    cmp("rst.res_valid", 32'(rv0), 32'd0);
    cmp("rst.res_data", 32'(rd0), 32'd0);
    cmp("rst.call_count", 32'(cc0), 32'd0);
    cmp("rst.call_count2", 32'(cc2), 32'd0);
    rst = 1'b0;
    av  = 1'b0;
    rr  = 1'b0;
    step();
    @(negedge clk);
    cmp("post_rst.arg_ready", 32'(ar0), 32'd1);

    // Args 1,0,1 then a result value that changes every cycle.
    av = 1'b1;
    ad = 1'b1;
    step();
    ad = 1'b0;
    step();
    ad = 1'b1;
    step();
    av = 1'b0;
    first  = '{0, 0, 0};
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      cr = 3'(k);
      @(negedge clk);
      if (rv0 && first[0] == 0) first[0] = k;
      if (rv1 && first[1] == 0) first[1] = k;
      if (rv2 && first[2] == 0) first[2] = k;
      if (cs0) pulses++;
      if (k == 1) cmp("basic.start_cycle1", 32'(cs0), 32'd1);
      step();
    end
    cmp("basic.call_args", 32'(ca0), 32'b101);
    cmp("basic.start_pulses", 32'(pulses), 32'd1);
    cmp("lat.wait1", 32'(first[0]), 32'd3);
    cmp("lat.wait0", 32'(first[1]), 32'd2);
    cmp("lat.wait4", 32'(first[2]), 32'd6);
    cmp("sample.wait1", 32'(rd0), 32'b010);
    cmp("sample.wait0", 32'(rd1), 32'd1);
    cmp("sample.wait4", 32'(rd2), 32'd5);

    // Backpressure: results held, arguments refused.
    av = 1'b1;
    ad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp("bp.arg_ready", 32'(ar0), 32'd0);
      cmp("bp.res_data", 32'(rd0), 32'b010);
      cmp("bp.call_args", 32'(ca0), 32'b101);
      cmp("bp.call_count", 32'(cc0), 32'd0);
      step();
    end
    rr = 1'b1;
    step();
    @(negedge clk);
    cmp("hs.call_count0", 32'(cc0), 32'd1);
    cmp("hs.call_count1", 32'(cc1), 32'd1);
    cmp("hs.call_count2", 32'(cc2), 32'd1);
    cmp("hs.arg_ready", 32'(ar0), 32'd1);

    // Free running traffic.
    for (int n = 0; n < 24; n++) begin
      ad = 1'(n % 3 == 0);
      cr = 3'(n * 5 + 3);
      step();
    end

    // Reset after two accepted arguments, then a fresh 1,1,1 call.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr  = 1'b0;
    av  = 1'b1;
    ad  = 1'b0;
    step();
    step();
    rst = 1'b1;
    ad  = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    av = 1'b0;
    @(negedge clk);
    cmp("mid.call_args", 32'(ca0), 32'b111);
    cmp("mid.call_start", 32'(cs0), 32'd1);
    cmp("mid.call_count", 32'(cc0), 32'd0);
    rr = 1'b1;
    for (int k = 0; k < 7; k++) step();
    @(negedge clk);
    cmp("mid.done0", 32'(cc0), 32'd1);
    cmp("mid.done1", 32'(cc1), 32'd1);
    cmp("mid.done2", 32'(cc2), 32'd1);

    // Two-bit counter wrap on the wait-4 instance.
    rst = 1'b1;
    step();
    rst  = 1'b0;
    av   = 1'b1;
    rr   = 1'b1;
    prev = 2'd0;
    for (int n = 0; n < 80; n++) begin
      ad = 1'(n);
      cr = 3'(n + 2);
      @(negedge clk);
      if (cc2 != prev) begin
        q.push_back(cc2);
        prev = cc2;
      end
      if (q.size() == 5) break;
      step();
    end
    cmp("wrap.count_changes", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q.size()) cmp($sformatf("wrap.seq%0d", i), 32'(q[i]),
                            32'(wexp[i]));
    end

    av = 1'b0;
    rr = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
